// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe turn controller: mark encodings,
// FSM state type and the table of the eight winning lines.
package ttt_pkg;

  typedef logic [1:0] mark_t;

  localparam mark_t MARK_NONE = 2'b00;
  localparam mark_t MARK_O    = 2'b01;
  localparam mark_t MARK_X    = 2'b10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_SEL = 3'd1,
    COMMIT   = 3'd2,
    CHECK    = 3'd3,
    OVER     = 3'd4
  } state_t;

  localparam int NUM_LINES = 8;

  // Cell indices of each winning line, written from line 7 down to line 0:
  // rows 0-2, columns 3-5, diagonals 6-7.
  localparam logic [NUM_LINES-1:0][2:0][3:0] WIN_LINES = {
    {4'd6, 4'd4, 4'd2},   // line 7: anti-diagonal
    {4'd8, 4'd4, 4'd0},   // line 6: main diagonal
    {4'd8, 4'd5, 4'd2},   // line 5: right column
    {4'd7, 4'd4, 4'd1},   // line 4: middle column
    {4'd6, 4'd3, 4'd0},   // line 3: left column
    {4'd8, 4'd7, 4'd6},   // line 2: bottom row
    {4'd5, 4'd4, 4'd3},   // line 1: middle row
    {4'd2, 4'd1, 4'd0}    // line 0: top row
  };

  // Hands the move to the other player.
  function automatic mark_t other_mark(input mark_t m);
    return (m == MARK_O) ? MARK_X : MARK_O;
  endfunction

endpackage

// File: rtl/win_detector.sv
// Combinational line check: hit is set when any of the eight winning lines
// holds three cells equal to the given (non-empty) mark.
module win_detector
  import ttt_pkg::*;
(
  input  mark_t [8:0] cells,
  input  mark_t       mark,
  output logic        hit
);

  // Scan every line and OR together the lines fully owned by mark.
  always_comb begin
    // NOTE: hit gets a default before the loop so no path leaves it unassigned,
    // which would otherwise infer a latch.
    hit = 1'b0;
    for (int l = 0; l < NUM_LINES; l++) begin
      logic full;
      full = 1'b1;
      for (int k = 0; k < 3; k++) begin
        if (cells[WIN_LINES[l][k]] != mark) full = 1'b0;
      end
      if (full && (mark != MARK_NONE)) hit = 1'b1;
    end
  end

endmodule

// File: rtl/turn_controller.sv
// Turn sequencing for tic-tac-toe: accepts or refuses cell selections,
// strobes accepted moves to the recorder, checks for a win once the grid
// has been updated, and optionally forfeits turns that run out of time.
module turn_controller
  import ttt_pkg::*;
#(
  parameter logic [1:0] START_MARK     = 2'b01,
  parameter int         TIMEOUT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sel_valid,
  input  logic [3:0] sel_pos,
  input  logic [1:0] y0,
  input  logic [1:0] y1,
  input  logic [1:0] y2,
  input  logic [1:0] y3,
  input  logic [1:0] y4,
  input  logic [1:0] y5,
  input  logic [1:0] y6,
  input  logic [1:0] y7,
  input  logic [1:0] y8,
  output logic [1:0] mark,
  output logic [3:0] position,
  output logic       game_state,
  output logic [1:0] turn,
  output logic [1:0] winner,
  output logic       reject,
  output logic       timeout
);

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam int CNT_W      = TIMEOUT_EN ? (($clog2(TIMEOUT_CYCLES + 1) < 1) ? 1
                                                : $clog2(TIMEOUT_CYCLES + 1)) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  mark_t [8:0]      cells;
  logic             sel_free;
  logic             line_hit;

  assign cells = {y8, y7, y6, y5, y4, y3, y2, y1, y0};

  // A selection is legal only when it names cell 0-8 and that cell is empty.
  always_comb begin
    sel_free = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if ((sel_pos == 4'(i)) && (cells[i] == MARK_NONE)) sel_free = 1'b1;
    end
  end

  win_detector u_win_detector (
    .cells (cells),
    .mark  (turn),
    .hit   (line_hit)
  );

  // Game FSM with registered outputs; strobes default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      mark       <= MARK_NONE;
      position   <= '0;
      game_state <= 1'b0;
      turn       <= MARK_NONE;
      winner     <= MARK_NONE;
      reject     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let these pulse defaults be overridden
      // later in the same block without creating ordering races.
      mark     <= MARK_NONE;
      position <= '0;
      reject   <= 1'b0;
      timeout  <= 1'b0;

      case (state)
        IDLE, OVER: begin
          if (start) begin
            state      <= WAIT_SEL;
            game_state <= 1'b1;
            turn       <= START_MARK;
            winner     <= MARK_NONE;
            cnt        <= '0;
          end
        end

        WAIT_SEL: begin
          if (sel_valid && sel_free) begin
            // An accepted move beats a simultaneous timeout expiry.
            state    <= COMMIT;
            mark     <= turn;
            position <= sel_pos;
            cnt      <= '0;
          end else begin
            if (sel_valid) reject <= 1'b1;
            if (TIMEOUT_EN) begin
              if (cnt == CNT_LAST) begin
                turn    <= other_mark(turn);
                cnt     <= '0;
                timeout <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
        end

        COMMIT: state <= CHECK;

        CHECK: begin
          // The recorder has written the move by now, so the grid is current.
          if (line_hit) begin
            state      <= OVER;
            winner     <= turn;
            game_state <= 1'b0;
          end else begin
            state <= WAIT_SEL;
            turn  <= other_mark(turn);
            cnt   <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller: one instance with the timeout disabled
// covers moves, rejects, a win, reset mid-move and ignored inputs; a second
// instance with a 4-cycle timeout covers turn forfeit and selection priority.
module tb_turn_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: timeout disabled, grid driven by the bench as the recorder.
  logic       rst, start, sel_valid;
  logic [3:0] sel_pos;
  logic [1:0] g [9];
  logic [1:0] mark, turn, winner;
  logic [3:0] position;
  logic       game_state, reject, timeout;

  // Instance B: TIMEOUT_CYCLES = 4, grid stays empty.
  logic       b_rst, b_start, b_sel_valid;
  logic [3:0] b_sel_pos;
  logic [1:0] b_empty = 2'b00;
  logic [1:0] b_mark, b_turn, b_winner;
  logic [3:0] b_position;
  logic       b_game_state, b_reject, b_timeout;

  turn_controller #(.START_MARK(2'b01), .TIMEOUT_CYCLES(0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .sel_valid(sel_valid), .sel_pos(sel_pos),
    .y0(g[0]), .y1(g[1]), .y2(g[2]), .y3(g[3]), .y4(g[4]),
    .y5(g[5]), .y6(g[6]), .y7(g[7]), .y8(g[8]),
    .mark(mark), .position(position), .game_state(game_state), .turn(turn),
    .winner(winner), .reject(reject), .timeout(timeout)
  );

  turn_controller #(.START_MARK(2'b01), .TIMEOUT_CYCLES(4)) dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .sel_valid(b_sel_valid), .sel_pos(b_sel_pos),
    .y0(b_empty), .y1(b_empty), .y2(b_empty), .y3(b_empty), .y4(b_empty),
    .y5(b_empty), .y6(b_empty), .y7(b_empty), .y8(b_empty),
    .mark(b_mark), .position(b_position), .game_state(b_game_state), .turn(b_turn),
    .winner(b_winner), .reject(b_reject), .timeout(b_timeout)
  );

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock edge, then settle past it before checking or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a_reset(input string tag);
    check({tag, "_mark"},       8'(mark),       8'h00);
    check({tag, "_position"},   8'(position),   8'h00);
    check({tag, "_game_state"}, 8'(game_state), 8'h00);
    check({tag, "_turn"},       8'(turn),       8'h00);
    check({tag, "_winner"},     8'(winner),     8'h00);
    check({tag, "_reject"},     8'(reject),     8'h00);
    check({tag, "_timeout"},    8'(timeout),    8'h00);
  endtask

  // Play one legal move on instance A, acting as recorder during COMMIT,
  // and check the strobe and the turn after CHECK.
  task automatic move_a(input logic [3:0] pos, input logic [1:0] who,
                        input logic [1:0] next_turn, input string tag);
    sel_valid = 1'b1;
    sel_pos   = pos;
    tick();
    sel_valid = 1'b0;
    check({tag, "_mark"},     8'(mark),     8'(who));
    check({tag, "_position"}, 8'(position), 8'(pos));
    g[pos] = who;
    tick();
    check({tag, "_mark_clr"}, 8'(mark), 8'h00);
    tick();
    check({tag, "_turn"}, 8'(turn), 8'(next_turn));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sel_valid = 1'b0; sel_pos = '0;
    b_rst = 1'b1; b_start = 1'b0; b_sel_valid = 1'b0; b_sel_pos = '0;
    for (int i = 0; i < 9; i++) g[i] = 2'b00;
    tick();
    tick();
    check_a_reset("reset");
    rst = 1'b0;
    tick();
    check("idle_turn", 8'(turn), 8'h00);

    // Start a game: O moves first.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_game_state", 8'(game_state), 8'h01);
    check("start_turn",       8'(turn),       8'h01);
    check("start_winner",     8'(winner),     8'h00);

    // Legal centre move by O; X to move afterwards.
    move_a(4'd4, 2'b01, 2'b10, "centre");

    // Occupied cell and out-of-range cell are both refused.
    g[2] = 2'b01;
    sel_valid = 1'b1; sel_pos = 4'd2;
    tick();
    check("occ_reject", 8'(reject), 8'h01);
    check("occ_mark",   8'(mark),   8'h00);
    check("occ_turn",   8'(turn),   8'h10 >> 3);
    sel_pos = 4'd9;
    tick();
    check("range_reject", 8'(reject), 8'h01);
    check("range_mark",   8'(mark),   8'h00);
    check("range_turn",   8'(turn),   8'h02);
    sel_valid = 1'b0;
    tick();
    check("reject_pulse_end", 8'(reject), 8'h00);

    // Reset while in COMMIT clears everything the following cycle.
    sel_valid = 1'b1; sel_pos = 4'd0;
    tick();
    sel_valid = 1'b0;
    check("pre_rst_mark", 8'(mark), 8'h02);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_a_reset("rst_commit");
    tick();
    check("rst_commit_idle", 8'(game_state), 8'h00);
    for (int i = 0; i < 9; i++) g[i] = 2'b00;

    // Full game: O takes the top row.
    start = 1'b1;
    tick();
    start = 1'b0;
    move_a(4'd0, 2'b01, 2'b10, "g_o0");
    move_a(4'd3, 2'b10, 2'b01, "g_x3");
    move_a(4'd1, 2'b01, 2'b10, "g_o1");
    move_a(4'd4, 2'b10, 2'b01, "g_x4");
    sel_valid = 1'b1; sel_pos = 4'd2;
    tick();
    sel_valid = 1'b0;
    check("win_mark", 8'(mark), 8'h01);
    g[2] = 2'b01;
    tick();
    check("win_in_check", 8'(game_state), 8'h01);
    tick();
    check("win_winner",     8'(winner),     8'h01);
    check("win_game_state", 8'(game_state), 8'h00);

    // Selections in OVER are ignored without a reject.
    sel_valid = 1'b1; sel_pos = 4'd5;
    tick();
    sel_valid = 1'b0;
    check("over_sel_reject", 8'(reject), 8'h00);
    check("over_sel_mark",   8'(mark),   8'h00);
    check("over_sel_winner", 8'(winner), 8'h01);

    // Restart from OVER clears the winner and hands the move to O.
    for (int i = 0; i < 9; i++) g[i] = 2'b00;
    start = 1'b1;
    tick();
    check("restart_winner",     8'(winner),     8'h00);
    check("restart_turn",       8'(turn),       8'h01);
    check("restart_game_state", 8'(game_state), 8'h01);

    // Start held in WAIT_SEL changes nothing; the game still takes a move.
    tick();
    start = 1'b0;
    check("wait_start_turn",   8'(turn),   8'h01);
    check("wait_start_reject", 8'(reject), 8'h00);
    check("wait_start_mark",   8'(mark),   8'h00);
    move_a(4'd8, 2'b01, 2'b10, "after_start");

    // Instance B: forfeit after four idle WAIT_SEL cycles.
    b_rst = 1'b0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    check("to_start_turn", 8'(b_turn), 8'h01);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("to_wait%0d_timeout", i), 8'(b_timeout), 8'h00);
      check($sformatf("to_wait%0d_turn", i),    8'(b_turn),    8'h01);
    end
    tick();
    check("to_pulse",      8'(b_timeout), 8'h01);
    check("to_pulse_turn", 8'(b_turn),    8'h02);
    check("to_pulse_mark", 8'(b_mark),    8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("to_rewait%0d_timeout", i), 8'(b_timeout), 8'h00);
    end
    // Legal selection on the expiry cycle wins over the timeout.
    b_sel_valid = 1'b1; b_sel_pos = 4'd7;
    tick();
    b_sel_valid = 1'b0;
    check("to_sel_mark",     8'(b_mark),     8'h02);
    check("to_sel_position", 8'(b_position), 8'h07);
    check("to_sel_timeout",  8'(b_timeout),  8'h00);
    tick();
    tick();
    check("to_sel_next_turn", 8'(b_turn), 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/turn_controller.md
TURN_CONTROLLER -- requirements
Module: turn_controller

Interface
REQ-001 Parameter START_MARK, default 2'b01, mark of the player who moves first (01:O, 10:X).
REQ-002 Parameter TIMEOUT_CYCLES, default 0, cycles allowed per move in WAIT_SEL; 0 disables timeout.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  pulse; begins a new game when in IDLE or OVER.
REQ-006 sel_valid  in  1  player has confirmed a selection this cycle.
REQ-007 sel_pos  in  4  selected grid cell, 0-8 legal.
REQ-008 y0..y8  in  2 each  current grid from the marker/recorder stage (01:O, 10:X, 00:empty).
REQ-009 mark  out  2  move strobe to the recorder: 01/10 for exactly one cycle per accepted move, else 00.
REQ-010 position  out  4  cell of the accepted move, valid while mark != 00, else 0.
REQ-011 game_state  out  1  1 while a game is in progress (WAIT_SEL, COMMIT, CHECK), else 0.
REQ-012 turn  out  2  mark of the player to move (01/10); 00 in IDLE.
REQ-013 winner  out  2  winning mark once a game ends, 00 otherwise.
REQ-014 reject  out  1  one-cycle pulse for a refused selection.
REQ-015 timeout  out  1  one-cycle pulse when a turn is forfeited by timeout.

Function
REQ-016 FSM states SHALL be IDLE, WAIT_SEL, COMMIT, CHECK, OVER; all outputs registered.
REQ-017 IDLE: start=1 -> WAIT_SEL, turn<=START_MARK, winner<=00.
REQ-018 WAIT_SEL: sel_valid=1, sel_pos<=8 and y[sel_pos]==00 -> COMMIT; mark<=turn, position<=sel_pos (visible cycle N+1 for sample cycle N).
REQ-019 WAIT_SEL: sel_valid=1 with sel_pos>8 or occupied cell -> reject pulse next cycle, stay in WAIT_SEL, turn unchanged.
REQ-020 COMMIT lasts one cycle, then -> CHECK; mark returns to 00 on leaving COMMIT.
REQ-021 CHECK (cycle N+2, grid already updated by the recorder) evaluates the 8 lines (3 rows, 3 columns, 2 diagonals) for three cells equal to turn.
REQ-022 CHECK with a line -> OVER, winner<=turn; without -> WAIT_SEL, turn toggles 01<->10.
REQ-023 No draw state exists: the recorder keeps at most 3 marks per player, so play continues until a win.
REQ-024 OVER: game_state=0, winner and grid held; start=1 -> WAIT_SEL with turn<=START_MARK, winner<=00.
REQ-025 Timeout counter SHALL clear on entering WAIT_SEL and count each WAIT_SEL cycle; at TIMEOUT_CYCLES-1 without accepted move: turn toggles, counter clears, timeout pulse, mark stays 00.
REQ-026 Simultaneous legal selection and timeout expiry: selection wins, no timeout pulse.
REQ-027 sel_valid outside WAIT_SEL SHALL be ignored (no reject); start outside IDLE/OVER SHALL be ignored.
REQ-028 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1), minimum 1 bit.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE, mark=00, position=0, game_state=0, turn=00, winner=00, reject=0, timeout=0, counter=0, from any state including COMMIT.
REQ-030 rst has priority over start and sel_valid on the same edge.

Structure
REQ-031 Shared package ttt_pkg SHALL hold MARK_NONE/MARK_O/MARK_X, the FSM state enum and the 8-entry win-line cell-index table.
REQ-032 Line evaluation SHALL be a combinational sub-module win_detector (inputs 9 cells + mark, output hit).

Verification
REQ-033 Reset, start, sel_pos=4 legal -> mark=01, position=4 for one cycle; turn=10 after CHECK.
REQ-034 Occupied cell y2=01, sel_pos=2 -> reject=1 one cycle, mark=00, turn unchanged; sel_pos=9 -> same.
REQ-035 O on 0,1 then sel_pos=2 -> CHECK finds row, winner=01, game_state=0; next start -> winner=00, turn=01.
REQ-036 TIMEOUT_CYCLES=4, no selection -> timeout pulse 4th WAIT_SEL cycle, turn 01->10; legal selection on that cycle -> mark strobe, no timeout.
REQ-037 rst=1 during COMMIT -> next cycle mark=00, state IDLE, all outputs at reset values.
REQ-038 sel_valid in OVER and start during WAIT_SEL -> no reject, no state change.
